// File: rtl/sop_pkg.sv
// Shared types and constants for the SOP truth-table sweep checker.
package sop_pkg;

  localparam int unsigned NUM_VEC               = 16;
  localparam int unsigned SETTLE_CYCLES_DEFAULT = 2;

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StSample,
    StDone
  } state_e;

endpackage

// File: rtl/sop_sweep_checker.sv
// Sweeps all 16 input vectors of a 4-input SOP unit and compares z1 against an
// expected truth table, reporting mismatch count, first failing index and pass.
module sop_sweep_checker
  import sop_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [15:0] exp_mask_i,
  input  logic        z1_i,
  output logic        x1_o,
  output logic        x2_o,
  output logic        x3_o,
  output logic        x4_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_o,
  output logic [4:0]  err_count_o,
  output logic [3:0]  first_err_idx_o
);

  // SETTLE_CYCLES of 0 and 1 both leave DRIVE after a single cycle.
  localparam logic [3:0] SettleLast = (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0] IdxLast    = 4'(NUM_VEC - 1);
  localparam logic [4:0] ErrMax     = 5'(NUM_VEC);

  state_e      state_q;
  logic [3:0]  idx_q;
  logic [3:0]  settle_q;
  logic [15:0] mask_q;
  logic [3:0]  x_q;
  logic        busy_q;
  logic        done_q;
  logic        pass_q;
  logic [4:0]  err_q;
  logic [3:0]  first_q;
  logic        mismatch;

  // Case-inequality so that an unknown z1 also counts as a mismatch.
  assign mismatch = (z1_i !== mask_q[idx_q]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      idx_q    <= 4'd0;
      settle_q <= 4'd0;
      mask_q   <= 16'd0;
      x_q      <= 4'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= 5'd0;
      first_q  <= 4'd0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i && !abort_i) begin
            mask_q   <= exp_mask_i;
            idx_q    <= 4'd0;
            x_q      <= 4'd0;
            err_q    <= 5'd0;
            pass_q   <= 1'b0;
            settle_q <= 4'd0;
            busy_q   <= 1'b1;
            state_q  <= StDrive;
          end
        end
        StDrive: begin
          if (abort_i) begin
            busy_q   <= 1'b0;
            pass_q   <= 1'b0;
            settle_q <= 4'd0;
            state_q  <= StIdle;
          end else if (settle_q == SettleLast) begin
            settle_q <= 4'd0;
            state_q  <= StSample;
          end else begin
            settle_q <= settle_q + 4'd1;
          end
        end
        StSample: begin
          if (abort_i) begin
            busy_q  <= 1'b0;
            pass_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            if (mismatch) begin
              if (err_q != ErrMax) err_q <= err_q + 5'd1;
              if (err_q == 5'd0) first_q <= idx_q;
            end
            if (idx_q == IdxLast) begin
              state_q <= StDone;
            end else begin
              // The next vector goes out with the index update so it settles a full window.
              idx_q   <= idx_q + 4'd1;
              x_q     <= idx_q + 4'd1;
              state_q <= StDrive;
            end
          end
        end
        StDone: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          pass_q  <= (err_q == 5'd0);
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign x1_o            = x_q[3];
  assign x2_o            = x_q[2];
  assign x3_o            = x_q[1];
  assign x4_o            = x_q[0];
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign pass_o          = pass_q;
  assign err_count_o     = err_q;
  assign first_err_idx_o = first_q;

endmodule
